serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial ripple-borrow subtractor: computes in1 − in2 − bin over WIDTH clock cycles, one bit per cycle LSB first, through a single 1-bit full-subtractor cell and a borrow flip-flop. It is the inverse arithmetic unit to the combinational ripple-carry adder in the arithmetic library. It trades latency for area: one cell instead of WIDTH. A start/done handshake lets a controller or bench drive it.

## Interface
- WIDTH, default 4: operand and result width in bits; legal for WIDTH ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  minuend; sampled with start.
- in2  input  WIDTH  subtrahend; sampled with start.
- bin  input  1  borrow-in; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  WIDTH  difference (in1 − in2 − bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out; 1 when in1 < in2 + bin.
- ovf  output  1  two's-complement overflow of the signed difference.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches in1, in2 into shift registers A and B, and loads bin into the borrow FF.
  - Clears the bit counter and moves to RUN.
  - start=0 stays in IDLE.
- RUN: each cycle the cell takes a=A[0], b=B[0] and br=borrow FF, and computes:
  - d = a^b^br
  - br' = (~a&b) | (~(a^b)&br)
- Per RUN cycle:
  - A and B shift right by one.
  - The result shift register shifts right with d inserted at the MSB.
  - The borrow FF takes br'.
  - The counter increments.
- On the cycle processing bit WIDTH−1:
  - Capture ovf = br ^ br', i.e. borrow into the MSB XOR borrow out of it.
  - Move to DONE.
- DONE:
  - diff = result register, bout = borrow FF.
  - done=1 for exactly this one cycle.
  - Move to IDLE unconditionally.
- diff, bout and ovf hold their values from the last completed operation until the next operation completes. They do not change during RUN.
- start while in RUN or DONE is ignored. It is not queued and must be reasserted in IDLE.
- Operands are captured only at start, so changes on in1, in2 or bin during RUN have no effect.

## Timing
- Reset:
  - state=IDLE.
  - busy=0, done=0, diff=0, bout=0, ovf=0.
  - Shift registers, counter and borrow FF are cleared.
- Reset wins over every other event, including start in the same cycle.
- Edge numbering: start sampled high in IDLE at edge 0.
  - busy=1 from edge 0 through edge WIDTH+1.
  - Bit i is processed at edge i+1, for i = 0..WIDTH−1.
  - done=1 and the outputs update at edge WIDTH+1; done falls at edge WIDTH+2.
  - busy=0 from edge WIDTH+1.
- Latency is WIDTH+1 cycles from start to done.
- Throughput is one operation per WIDTH+2 cycles; the earliest next start is sampled at edge WIDTH+2.
- Reset mid-operation: the operation is abandoned and no done pulse is produced. Outputs read 0 after the reset edge.
- The counter is $clog2(WIDTH) bits (minimum 1) and compares against WIDTH−1. No wrap is observable.

## Structure
- Shared arithmetic package holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the WIDTH default constant;
  - a counter-width function.
- Sub-module full_subtractor_1_bit: a, b, br inputs → d, br' outputs; purely combinational. It is instantiated once.
- The top holds the FSM, the three shift registers, the counter, the borrow FF and the output registers.

## Test plan
All scenarios use WIDTH=4.
- Basic: in1=7, in2=5, bin=1 → done at edge 5; diff=1, bout=0, ovf=0.
- Unsigned borrow: in1=5, in2=6, bin=0 → diff=15, bout=1, ovf=0. Then in1=0, in2=0, bin=1 → diff=15, bout=1, ovf=0.
- Signed overflow, positive: in1=7, in2=9, bin=1 → diff=13, bout=1, ovf=1.
- Signed overflow, negative: in1=8, in2=1, bin=0 → diff=7, bout=0, ovf=1.
- Handshake:
  - Pulse start again at edges 2 and 5 → both ignored; exactly one done pulse; outputs unchanged until edge 5.
  - A start at edge 6 → a second done at edge 11.
- Reset mid-operation: assert rst at edge 2 of in1=7, in2=5 → busy=0, diff=0, bout=0, ovf=0 after edge 2; no done pulse; a following start completes normally.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding,
// default operand width and the bit-counter sizing helper.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1, never fewer than one.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_1_bit.sv
// Single-bit full subtractor cell: d = a - b - br, with borrow out.
module full_subtractor_1_bit (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic d,
  output logic br_next
);

  assign d       = a ^ b ^ br;
  assign br_next = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: in1 - in2 - bin over WIDTH cycles,
// LSB first, through one full-subtractor cell and a borrow flip-flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             ovf_pend;
  logic             cell_d;
  logic             cell_br;

  full_subtractor_1_bit u_cell (
    .a       (a_sr[0]),
    .b       (b_sr[0]),
    .br      (borrow),
    .d       (cell_d),
    .br_next (cell_br)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; the shift registers are small and are reset like any
  // other flop so outputs read a defined 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      borrow   <= 1'b0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= in1;
            b_sr   <= in2;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {cell_d, res_sr[WIDTH-1:1]};
          borrow <= cell_br;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Overflow: borrow into the sign bit differs from borrow out of it.
            ovf_pend <= borrow ^ cell_br;
            state    <= DONE;
          end
        end
        DONE: begin
          diff  <= res_sr;
          bout  <= borrow;
          ovf   <= ovf_pend;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
